// File: rtl/system_pll_reset_seq_if.sv
// Control and status bundle between the PLL reset sequencer and the logic that owns it.
// The master side drives the lock flag and restart request; the slave side is the sequencer.
interface system_pll_reset_seq_if;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    modport master (
        output pll_locked,
        output restart_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  state,
        input  retry_cnt,
        input  loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  restart_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output fail,
        output state,
        output retry_cnt,
        output loss_cnt
    );
endinterface

// File: rtl/system_pll_reset_seq.sv
// Brings the system PLL from power-up to a qualified, stable lock with bounded retries,
// then releases the system reset. Everything runs on refclk.
module system_pll_reset_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    system_pll_reset_seq_if.slave bus
);

    localparam int SYNC_STAGES = 2;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);
    localparam logic [7:0]       LOSS_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] timer_reg;
    logic [CNT_W-1:0] timer_next;
    logic [3:0]       retry_reg;
    logic [3:0]       retry_next;
    logic [7:0]       loss_reg;
    logic [7:0]       loss_next;
    logic             pll_rst_reg;
    logic             sys_rst_reg;
    logic             ready_reg;
    logic             fail_reg;
    logic             attempt_failed;
    logic             state_entry;
    logic             locked_s;

    // pll_locked is asynchronous to refclk; only the far end of this chain is ever used.
    wire [SYNC_STAGES:0] sync_chain;
    assign sync_chain[0] = bus.pll_locked;

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic stage_reg;
        always_ff @(posedge refclk) begin
            if (rst) begin
                stage_reg <= 1'b0;
            end else begin
                stage_reg <= sync_chain[gi];
            end
        end
        assign sync_chain[gi+1] = stage_reg;
    end

    assign locked_s = sync_chain[SYNC_STAGES];

    always_comb begin
        state_next     = state_reg;
        retry_next     = retry_reg;
        loss_next      = loss_reg;
        attempt_failed = 1'b0;

        // A software restart beats any timeout or lock event seen in the same cycle.
        if (bus.restart_req) begin
            state_next = S_PLL_RST;
            retry_next = '0;
        end else begin
            unique case (state_reg)
                S_PLL_RST: begin
                    if (timer_reg == RST_LAST) begin
                        state_next = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_next = S_STABLE;
                    end else if (timer_reg == LOCK_LAST) begin
                        attempt_failed = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        attempt_failed = 1'b1;
                    end else if (timer_reg == STABLE_LAST) begin
                        state_next = S_RUN;
                        retry_next = '0;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_next = S_PLL_RST;
                        if (loss_reg != LOSS_MAX) begin
                            loss_next = loss_reg + 8'd1;
                        end
                    end
                end
                S_FAIL: begin
                    state_next = S_FAIL;
                end
                default: begin
                    state_next = S_PLL_RST;
                end
            endcase

            if (attempt_failed) begin
                if (retry_reg == RETRY_LIMIT) begin
                    state_next = S_FAIL;
                end else begin
                    retry_next = retry_reg + 4'd1;
                    state_next = S_PLL_RST;
                end
            end
        end

        // Restart re-enters PLL_RST even from PLL_RST, so it must also clear the timer.
        state_entry = bus.restart_req || (state_next != state_reg);
        timer_next  = state_entry ? '0 : timer_reg + TIMER_ONE;
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg   <= S_PLL_RST;
            timer_reg   <= '0;
            retry_reg   <= '0;
            loss_reg    <= '0;
            pll_rst_reg <= 1'b1;
            sys_rst_reg <= 1'b1;
            ready_reg   <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retry_reg   <= retry_next;
            loss_reg    <= loss_next;
            pll_rst_reg <= (state_next == S_PLL_RST) || (state_next == S_FAIL);
            sys_rst_reg <= (state_next != S_RUN);
            ready_reg   <= (state_next == S_RUN);
            fail_reg    <= (state_next == S_FAIL);
        end
    end

    assign bus.pll_rst   = pll_rst_reg;
    assign bus.sys_rst   = sys_rst_reg;
    assign bus.ready     = ready_reg;
    assign bus.fail      = fail_reg;
    assign bus.state     = state_reg;
    assign bus.retry_cnt = retry_reg;
    assign bus.loss_cnt  = loss_reg;

endmodule

// File: tb/tb_system_pll_reset_seq.sv
// Bench for system_pll_reset_seq: directed scenarios plus random lock/restart/reset traffic,
// all checked against a behavioural model that tracks time since state entry.
module tb_system_pll_reset_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 16;

    localparam logic [18:0] RESET_VEC = {1'b1, 1'b1, 17'd0};

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    system_pll_reset_seq_if bus ();

    system_pll_reset_seq #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 refclk = ~refclk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase number, edge at which the phase was entered, counters, and the
    // pll_locked samples still in flight towards the sequencer (two-edge delay).
    int cyc     = 0;
    int m_state = 0;
    int m_entry = 0;
    int m_retry = 0;
    int m_loss  = 0;
    bit hist[$];

    logic [18:0] obs;
    assign obs = {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.state, bus.retry_cnt, bus.loss_cnt};

    function automatic logic [18:0] exp_vec();
        logic [2:0] st;
        st = 3'(m_state);
        return {m_state == 0 || m_state == 4, m_state != 3, m_state == 3, m_state == 4,
                st, 4'(m_retry), 8'(m_loss)};
    endfunction

    function automatic void attempt_fail();
        if (m_retry == MAX_RETRIES) begin
            m_state = 4;
        end else begin
            m_retry++;
            m_state = 0;
        end
        m_entry = cyc;
    endfunction

    // One refclk cycle: advance the model with the inputs present at the edge,
    // then return at the falling edge where outputs are sampled and inputs changed.
    task automatic tick();
        bit ls;
        int el;
        @(posedge refclk);
        cyc++;
        if (rst) begin
            m_state = 0;
            m_entry = cyc;
            m_retry = 0;
            m_loss  = 0;
            hist    = '{1'b0, 1'b0};
        end else begin
            ls = hist.pop_front();
            hist.push_back(bus.pll_locked);
            el = cyc - m_entry - 1;
            if (bus.restart_req) begin
                m_state = 0;
                m_entry = cyc;
                m_retry = 0;
            end else begin
                case (m_state)
                    0: if (el == RST_CYCLES - 1) begin m_state = 1; m_entry = cyc; end
                    1: begin
                        if (ls) begin m_state = 2; m_entry = cyc; end
                        else if (el == LOCK_TIMEOUT - 1) attempt_fail();
                    end
                    2: begin
                        if (!ls) attempt_fail();
                        else if (el == STABLE_CYCLES - 1) begin
                            m_state = 3; m_entry = cyc; m_retry = 0;
                        end
                    end
                    3: begin
                        if (!ls) begin
                            if (m_loss < 255) m_loss++;
                            m_state = 0;
                            m_entry = cyc;
                        end
                    end
                    default: begin end
                endcase
            end
        end
        @(negedge refclk);
    endtask

    task automatic test_reset();
        bus.pll_locked  = 1'b1;
        bus.restart_req = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_outputs got=%h want=%h", obs, RESET_VEC); end
        n_cmp++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL reset_model got=%h want=%h", obs, exp_vec()); end
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_cmp++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_over_restart got=%h want=%h", obs, RESET_VEC); end
        $display("test_reset: state=%0d pll_rst=%0b sys_rst=%0b", bus.state, bus.pll_rst, bus.sys_rst);
    endtask

    task automatic test_clean_bringup();
        int hi;
        int n;
        bit done;
        bus.pll_locked = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.pll_rst !== 1'b1) begin n_err++; $display("FAIL bringup_prst_start got=%0b want=1", bus.pll_rst); end
        hi = 1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL bringup_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            if (bus.pll_rst) hi++; else done = 1;
        end
        n_cmp++;
        if (!done || hi != RST_CYCLES) begin n_err++; $display("FAIL bringup_prst_len got=%0d want=%0d", hi, RST_CYCLES); end
        repeat (4) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL bringup_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
        end
        n_cmp++;
        if (bus.state !== 3'd1) begin n_err++; $display("FAIL bringup_wait_state got=%0d want=1", bus.state); end
        bus.pll_locked = 1'b1;
        n = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            n++;
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL bringup_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            if (n == 3) begin
                n_cmp++;
                if (bus.state !== 3'd2) begin n_err++; $display("FAIL bringup_stable_entry got=%0d want=2", bus.state); end
            end
            done = bus.ready;
        end
        n_cmp++;
        if (!done || n != 3 + STABLE_CYCLES) begin n_err++; $display("FAIL bringup_ready_latency got=%0d want=%0d", n, 3 + STABLE_CYCLES); end
        n_cmp++;
        if (bus.sys_rst !== 1'b0 || bus.state !== 3'd3 || bus.retry_cnt !== 4'd0) begin
            n_err++; $display("FAIL bringup_run got sys_rst=%0b state=%0d retry=%0d want 0/3/0", bus.sys_rst, bus.state, bus.retry_cnt);
        end
        $display("test_clean_bringup: pll_rst_len=%0d lock_to_ready=%0d", hi, n);
    endtask

    task automatic test_lock_glitch();
        bit done;
        int hi;
        bus.pll_locked = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            done = (bus.state == 3'd1);
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL glitch_wait_lock state=%0d want=1", bus.state); end
        repeat ($urandom_range(0, 6)) tick();
        bus.pll_locked = 1'b1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            done = (bus.state == 3'd2);
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL glitch_reach_stable state=%0d want=2", bus.state); end
        repeat (5) tick();
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            done = (bus.state == 3'd0);
        end
        n_cmp++;
        if (!done || bus.retry_cnt !== 4'd1 || bus.pll_rst !== 1'b1) begin
            n_err++; $display("FAIL glitch_retry got state=%0d retry=%0d pll_rst=%0b want 0/1/1", bus.state, bus.retry_cnt, bus.pll_rst);
        end
        hi = 1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            if (bus.pll_rst) hi++; else done = 1;
        end
        n_cmp++;
        if (hi != RST_CYCLES) begin n_err++; $display("FAIL glitch_prst_len got=%0d want=%0d", hi, RST_CYCLES); end
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            done = bus.ready;
        end
        n_cmp++;
        if (!done || bus.retry_cnt !== 4'd0) begin n_err++; $display("FAIL glitch_rerun got ready=%0b retry=%0d want 1/0", bus.ready, bus.retry_cnt); end
        $display("test_lock_glitch: back in run, retry=%0d", bus.retry_cnt);
    endtask

    task automatic test_loss_in_run();
        bit done;
        int n;
        int want;
        bus.pll_locked = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat ($urandom_range(4, 10)) tick();
        bus.pll_locked = 1'b1;
        done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            done = bus.ready;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL loss_first_run ready=%0b want=1", bus.ready); end
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                n_cmp++;
                if (obs !== exp_vec()) begin n_err++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            end
            bus.pll_locked = 1'b0;
            n = 0;
            done = 0;
            for (int k = 0; k < 10 && !done; k++) begin
                tick();
                n++;
                n_cmp++;
                if (obs !== exp_vec()) begin n_err++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
                done = bus.sys_rst;
            end
            want = (i + 1 > 255) ? 255 : i + 1;
            n_cmp++;
            if (n != 3 || bus.ready !== 1'b0 || bus.loss_cnt !== 8'(want)) begin
                n_err++; $display("FAIL loss_reassert i=%0d delay=%0d want 3 ready=%0b loss=%0d want %0d", i, n, bus.ready, bus.loss_cnt, want);
            end
            repeat ($urandom_range(0, 2)) tick();
            bus.pll_locked = 1'b1;
            done = 0;
            for (int k = 0; k < 60 && !done; k++) begin
                tick();
                n_cmp++;
                if (obs !== exp_vec()) begin n_err++; $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
                done = bus.ready;
            end
            n_cmp++;
            if (!done) begin n_err++; $display("FAIL loss_rerun i=%0d ready=%0b want=1", i, bus.ready); end
        end
        n_cmp++;
        if (bus.loss_cnt !== 8'd255) begin n_err++; $display("FAIL loss_saturate got=%0d want=255", bus.loss_cnt); end
        $display("test_loss_in_run: loss_cnt=%0d", bus.loss_cnt);
    endtask

    task automatic test_rst_mid_stable();
        bit done;
        bus.pll_locked = 1'b0;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            done = (bus.state == 3'd0);
        end
        bus.pll_locked = 1'b1;
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL rst_mid_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            done = (bus.state == 3'd2);
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL rst_mid_reach_stable state=%0d want=2", bus.state); end
        repeat (3) tick();
        n_cmp++;
        if (bus.loss_cnt !== 8'd255 || bus.state !== 3'd2) begin
            n_err++; $display("FAIL rst_mid_pre got loss=%0d state=%0d want 255/2", bus.loss_cnt, bus.state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL rst_mid_stable got=%h want=%h", obs, RESET_VEC); end
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin n_err++; $display("FAIL rst_mid_after got=%h want=%h", obs, exp_vec()); end
        $display("test_rst_mid_stable: state=%0d loss_cnt=%0d", bus.state, bus.loss_cnt);
    endtask

    task automatic test_never_lock();
        int run_st[$];
        int run_len[$];
        int run_retry[$];
        int exp_st[6]    = '{0, 1, 0, 1, 0, 1};
        int exp_len[6]   = '{RST_CYCLES, LOCK_TIMEOUT, RST_CYCLES, LOCK_TIMEOUT, RST_CYCLES, LOCK_TIMEOUT};
        int exp_retry[7] = '{0, 0, 1, 1, 2, 2, 2};
        int cur;
        int len;
        bus.pll_locked = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        cur = int'(bus.state);
        len = 1;
        run_retry.push_back(int'(bus.retry_cnt));
        for (int k = 0; k < 200 && bus.fail !== 1'b1; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL never_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
            if (int'(bus.state) == cur) begin
                len++;
            end else begin
                run_st.push_back(cur);
                run_len.push_back(len);
                cur = int'(bus.state);
                len = 1;
                run_retry.push_back(int'(bus.retry_cnt));
            end
        end
        n_cmp++;
        if (bus.fail !== 1'b1 || run_st.size() != 6 || run_retry.size() != 7) begin
            n_err++; $display("FAIL never_lock_shape fail=%0b runs=%0d want fail=1 runs=6", bus.fail, run_st.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (run_st[i] != exp_st[i] || run_len[i] != exp_len[i]) begin
                    n_err++; $display("FAIL never_lock_run%0d got state=%0d len=%0d want %0d/%0d", i, run_st[i], run_len[i], exp_st[i], exp_len[i]);
                end
            end
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (run_retry[i] != exp_retry[i]) begin
                    n_err++; $display("FAIL never_lock_retry%0d got=%0d want=%0d", i, run_retry[i], exp_retry[i]);
                end
            end
        end
        repeat (30) begin
            tick();
            n_cmp++;
            if (bus.state !== 3'd4 || bus.fail !== 1'b1 || bus.pll_rst !== 1'b1 || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0 || bus.retry_cnt !== 4'd2) begin
                n_err++; $display("FAIL never_lock_hold got=%h want state=4 fail=1 pll_rst=1 sys_rst=1 retry=2", obs);
            end
        end
        $display("test_never_lock: runs=%0d state=%0d retry=%0d", run_st.size(), bus.state, bus.retry_cnt);
    endtask

    task automatic test_restart();
        bit done;
        int hi;
        n_cmp++;
        if (bus.state !== 3'd4) begin n_err++; $display("FAIL restart_pre got state=%0d want=4", bus.state); end
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_cmp++;
        if (bus.state !== 3'd0 || bus.fail !== 1'b0 || bus.retry_cnt !== 4'd0 || bus.pll_rst !== 1'b1) begin
            n_err++; $display("FAIL restart_from_fail got state=%0d fail=%0b retry=%0d want 0/0/0", bus.state, bus.fail, bus.retry_cnt);
        end
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin tick(); done = (bus.state == 3'd1); end
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin tick(); done = (bus.state == 3'd0); end
        n_cmp++;
        if (!done || bus.retry_cnt !== 4'd1) begin n_err++; $display("FAIL restart_first_timeout retry=%0d want=1", bus.retry_cnt); end
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin tick(); done = (bus.state == 3'd1); end
        repeat (LOCK_TIMEOUT - 1) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL restart_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
        end
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_cmp++;
        if (bus.state !== 3'd0 || bus.retry_cnt !== 4'd0) begin
            n_err++; $display("FAIL restart_at_timeout got state=%0d retry=%0d want 0/0", bus.state, bus.retry_cnt);
        end
        repeat (2) tick();
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        hi = 1;
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            tick();
            if (bus.pll_rst) hi++; else done = 1;
        end
        n_cmp++;
        if (hi != RST_CYCLES) begin n_err++; $display("FAIL restart_in_pll_rst len=%0d want=%0d", hi, RST_CYCLES); end
        $display("test_restart: state=%0d retry=%0d pll_rst_len=%0d", bus.state, bus.retry_cnt, hi);
    endtask

    task automatic test_random();
        bus.pll_locked  = 1'b0;
        bus.restart_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) bus.pll_locked = ~bus.pll_locked;
            bus.restart_req = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin n_err++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs, exp_vec()); end
        end
        rst = 1'b0;
        bus.restart_req = 1'b0;
        $display("test_random: ended state=%0d loss_cnt=%0d", bus.state, bus.loss_cnt);
    endtask

    initial begin
        rst = 1'b1;
        bus.pll_locked  = 1'b0;
        bus.restart_req = 1'b0;
        test_reset();
        test_clean_bringup();
        test_lock_glitch();
        test_loss_in_run();
        test_rst_mid_stable();
        test_never_lock();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
